// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register constants and control bundle layout for the 16-bit core
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 8;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam int CTRL_EX_LSB  = 0;
    localparam int CTRL_MEM_LSB = 4;
    localparam int CTRL_WB_LSB  = 6;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Field layout of the opaque control bundle; EX never looks inside it.
    typedef struct packed {
        logic [CTRL_W-CTRL_WB_LSB-1:0]       wb;
        logic [CTRL_WB_LSB-CTRL_MEM_LSB-1:0] mem;
        logic [CTRL_MEM_LSB-CTRL_EX_LSB-1:0] ex;
    } ctrl_t;

    function automatic logic src_hit(input logic en, input logic [ADDR_W-1:0] src,
                                     input logic [ADDR_W-1:0] dst);
        return en && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select: R0, EX/MEM result, MEM/WB result or captured RF data
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic [ADDR_W-1:0] i_exm_dst_addr,
    input  logic              i_exm_we,
    input  logic              i_exm_is_load,
    input  logic [DATA_W-1:0] i_exm_result,
    input  logic [ADDR_W-1:0] i_mwb_dst_addr,
    input  logic              i_mwb_we,
    input  logic [DATA_W-1:0] i_mwb_result,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_rf_data;
        if (i_addr == REG_ZERO) begin
            o_data = '0;
        end else if (i_exm_we && !i_exm_is_load && (i_exm_dst_addr == i_addr)) begin
            o_data = i_exm_result;
        end else if (i_mwb_we && (i_mwb_dst_addr == i_addr)) begin
            o_data = i_mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_fwd.sv
// rtl/id_ex_fwd.sv - ID->EX pipeline register with operand bypass, load-use stall and halt
module id_ex_fwd
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_p0_addr,
    input  logic [ADDR_W-1:0] id_p1_addr,
    input  logic              id_re0,
    input  logic              id_re1,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_p0,
    input  logic [DATA_W-1:0] rf_p1,
    input  logic [ADDR_W-1:0] exm_dst_addr,
    input  logic              exm_we,
    input  logic              exm_is_load,
    input  logic [DATA_W-1:0] exm_result,
    input  logic [ADDR_W-1:0] mwb_dst_addr,
    input  logic              mwb_we,
    input  logic [DATA_W-1:0] mwb_result,
    input  logic              flush,
    input  logic              hlt,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op0,
    output logic [DATA_W-1:0] ex_op1,
    output logic [ADDR_W-1:0] ex_dst_addr,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       stall_cnt
);

    logic              r_ex_valid;
    logic              r_ex_we;
    logic              r_ex_is_load;
    logic [ADDR_W-1:0] r_p0_addr;
    logic [ADDR_W-1:0] r_p1_addr;
    logic [DATA_W-1:0] r_p0_data;
    logic [DATA_W-1:0] r_p1_data;
    logic [ADDR_W-1:0] r_dst_addr;
    ctrl_t             r_ctrl;
    logic              r_halted;
    logic [15:0]       r_stall_cnt;

    logic              w_load_in_ex;
    logic              w_stall;
    logic              w_bubble;

    assign w_load_in_ex = r_ex_valid && r_ex_is_load && (r_dst_addr != REG_ZERO);
    assign w_stall      = !r_halted && w_load_in_ex && id_valid &&
                          (src_hit(id_re0, id_p0_addr, r_dst_addr) ||
                           src_hit(id_re1, id_p1_addr, r_dst_addr));
    assign w_bubble     = r_halted || hlt || flush || w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_we      <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_p0_addr    <= '0;
            r_p1_addr    <= '0;
            r_p0_data    <= '0;
            r_p1_data    <= '0;
            r_dst_addr   <= '0;
            r_ctrl       <= '0;
            r_halted     <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            // A stall overridden by a flush never holds ID, so it is not a stall cycle.
            if (w_stall && !flush && (r_stall_cnt != STALL_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (hlt) begin
                r_halted <= 1'b1;
            end
            if (w_bubble) begin
                r_ex_valid   <= 1'b0;
                r_ex_we      <= 1'b0;
                r_ex_is_load <= 1'b0;
            end else begin
                r_ex_valid   <= id_valid;
                r_ex_we      <= id_we && id_valid;
                r_ex_is_load <= id_is_load && id_valid;
                r_p0_addr    <= id_p0_addr;
                r_p1_addr    <= id_p1_addr;
                r_p0_data    <= rf_p0;
                r_p1_data    <= rf_p1;
                r_dst_addr   <= id_dst_addr;
                r_ctrl       <= id_ctrl;
            end
        end
    end

    fwd_mux u_fwd0 (
        .i_addr         (r_p0_addr),
        .i_rf_data      (r_p0_data),
        .i_exm_dst_addr (exm_dst_addr),
        .i_exm_we       (exm_we),
        .i_exm_is_load  (exm_is_load),
        .i_exm_result   (exm_result),
        .i_mwb_dst_addr (mwb_dst_addr),
        .i_mwb_we       (mwb_we),
        .i_mwb_result   (mwb_result),
        .o_data         (ex_op0)
    );

    fwd_mux u_fwd1 (
        .i_addr         (r_p1_addr),
        .i_rf_data      (r_p1_data),
        .i_exm_dst_addr (exm_dst_addr),
        .i_exm_we       (exm_we),
        .i_exm_is_load  (exm_is_load),
        .i_exm_result   (exm_result),
        .i_mwb_dst_addr (mwb_dst_addr),
        .i_mwb_we       (mwb_we),
        .i_mwb_result   (mwb_result),
        .o_data         (ex_op1)
    );

    assign stall_id    = w_stall;
    assign ex_valid    = r_ex_valid;
    assign ex_we       = r_ex_we;
    assign ex_is_load  = r_ex_is_load;
    assign ex_dst_addr = r_dst_addr;
    assign ex_ctrl     = r_ctrl;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_fwd.sv
// tb/tb_id_ex_fwd.sv - scoreboard bench for id_ex_fwd against a behavioural pipeline model
module tb_id_ex_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 0, id_re0 = 0, id_re1 = 0, id_we = 0, id_is_load = 0;
    logic [3:0]  id_p0_addr = 0, id_p1_addr = 0, id_dst_addr = 0;
    logic [7:0]  id_ctrl = 0;
    logic [15:0] rf_p0 = 0, rf_p1 = 0;
    logic [3:0]  exm_dst_addr = 0, mwb_dst_addr = 0;
    logic        exm_we = 0, exm_is_load = 0, mwb_we = 0;
    logic [15:0] exm_result = 0, mwb_result = 0;
    logic        flush = 0, hlt = 0;
    logic        stall_id, ex_valid, ex_we, ex_is_load;
    logic [15:0] ex_op0, ex_op1, stall_cnt;
    logic [3:0]  ex_dst_addr;
    logic [7:0]  ex_ctrl;

    id_ex_fwd dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_p0_addr(id_p0_addr),
        .id_p1_addr(id_p1_addr), .id_re0(id_re0), .id_re1(id_re1),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_ctrl(id_ctrl), .rf_p0(rf_p0), .rf_p1(rf_p1),
        .exm_dst_addr(exm_dst_addr), .exm_we(exm_we), .exm_is_load(exm_is_load),
        .exm_result(exm_result), .mwb_dst_addr(mwb_dst_addr), .mwb_we(mwb_we),
        .mwb_result(mwb_result), .flush(flush), .hlt(hlt), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_op0(ex_op0), .ex_op1(ex_op1),
        .ex_dst_addr(ex_dst_addr), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Instruction sitting in EX; known=0 once a bubble has made the data fields don't-care.
    typedef struct {
        bit v, we, ld, known, re0, re1;
        bit [3:0] a0, a1, dst;
        bit [7:0] ctrl;
        bit [15:0] d0, d1;
    } ex_t;

    typedef struct {
        bit stall, v, we, ld, known;
        bit [15:0] op0, op1, cnt;
        bit [3:0] dst;
        bit [7:0] ctrl;
    } exp_t;

    exp_t q[$];
    ex_t  m;
    bit   m_halted;
    int   m_cnt;
    int   n_vec = 0;
    int   n_err = 0;

    bit        sh_exm_we, sh_exm_ld, sh_mwb_we;
    bit [3:0]  sh_exm_dst, sh_mwb_dst;
    bit [15:0] sh_exm_res, sh_mwb_res;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic bit m_stall();
        return !m_halted && m.v && m.ld && id_valid && m.dst != 0 &&
               ((id_re0 && id_p0_addr == m.dst) || (id_re1 && id_p1_addr == m.dst));
    endfunction

    function automatic bit [15:0] fwd(input bit [3:0] a, input bit [15:0] d);
        if (a == 0) return 16'h0000;
        if (exm_we && !exm_is_load && exm_dst_addr == a) return exm_result;
        if (mwb_we && mwb_dst_addr == a) return mwb_result;
        return d;
    endfunction

    task automatic settle();
        exp_t e;
        e.stall = m_stall();
        e.v = m.v; e.we = m.we; e.ld = m.ld; e.known = m.known;
        e.op0 = fwd(m.a0, m.d0); e.op1 = fwd(m.a1, m.d1);
        e.dst = m.dst; e.ctrl = m.ctrl; e.cnt = 16'(m_cnt);
        q.push_back(e);
        assert (!(m.v && exm_we && exm_is_load && exm_dst_addr != 0 &&
                  ((m.re0 && m.a0 == exm_dst_addr) || (m.re1 && m.a1 == exm_dst_addr))))
            else $error("load in EX/MEM feeds the EX consumer");
        @(negedge clk);
    endtask

    task automatic advance();
        bit st;
        st = m_stall();
        @(posedge clk);
        sh_mwb_we = sh_exm_we; sh_mwb_dst = sh_exm_dst;
        sh_mwb_res = sh_exm_ld ? 16'($urandom) : sh_exm_res;
        sh_exm_we = m.we; sh_exm_ld = m.ld; sh_exm_dst = m.dst; sh_exm_res = 16'($urandom);
        if (rst) begin
            m = '{default: 0};
            m.known = 1;
            m_halted = 0;
            m_cnt = 0;
        end else begin
            if (st && !flush) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (m_halted || hlt || flush || st) begin
                m.v = 0; m.we = 0; m.ld = 0; m.known = 0; m.re0 = 0; m.re1 = 0;
                if (hlt) m_halted = 1;
            end else begin
                m.v = id_valid; m.we = id_we && id_valid; m.ld = id_is_load && id_valid;
                m.re0 = id_re0; m.re1 = id_re1;
                m.a0 = id_p0_addr; m.a1 = id_p1_addr; m.dst = id_dst_addr;
                m.ctrl = id_ctrl; m.d0 = rf_p0; m.d1 = rf_p1; m.known = 1;
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input bit [3:0] p0, input bit [3:0] p1, input bit r0,
                          input bit r1, input bit [3:0] dst, input bit we, input bit ld);
        id_valid = v; id_p0_addr = p0; id_p1_addr = p1; id_re0 = r0; id_re1 = r1;
        id_dst_addr = dst; id_we = we; id_is_load = ld;
        id_ctrl = 8'($urandom); rf_p0 = 16'($urandom); rf_p1 = 16'($urandom);
    endtask

    task automatic clr_byp();
        exm_we = 0; exm_is_load = 0; exm_dst_addr = 0; exm_result = 0;
        mwb_we = 0; mwb_dst_addr = 0; mwb_result = 0; flush = 0; hlt = 0;
    endtask

    task automatic rand_in();
        set_id($urandom_range(0, 9) != 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom),
               $urandom_range(0, 3) == 0);
        exm_we = sh_exm_we; exm_is_load = sh_exm_ld; exm_dst_addr = sh_exm_dst;
        exm_result = sh_exm_res;
        mwb_we = sh_mwb_we; mwb_dst_addr = sh_mwb_dst; mwb_result = sh_mwb_res;
        flush = $urandom_range(0, 11) == 0;
        hlt = 0;
        rst = $urandom_range(0, 59) == 0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall_id", 16'(stall_id), 16'(e.stall));
            chk("ex_valid", 16'(ex_valid), 16'(e.v));
            chk("ex_we", 16'(ex_we), 16'(e.we));
            chk("ex_is_load", 16'(ex_is_load), 16'(e.ld));
            chk("stall_cnt", stall_cnt, e.cnt);
            if (e.known) begin
                chk("ex_op0", ex_op0, e.op0);
                chk("ex_op1", ex_op1, e.op1);
                chk("ex_dst_addr", 16'(ex_dst_addr), 16'(e.dst));
                chk("ex_ctrl", 16'(ex_ctrl), 16'(e.ctrl));
            end
        end
    end

    initial begin
        m = '{default: 0};
        m.known = 1;
        @(posedge clk);
        #1;
        settle(); advance();
        rst = 0;

        clr_byp(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset ex_valid", 16'(ex_valid), 16'h0);
        chk("reset stall_id", 16'(stall_id), 16'h0);
        chk("reset stall_cnt", stall_cnt, 16'h0);
        advance();

        // back-to-back dependency through EX/MEM
        set_id(1, 2, 3, 1, 1, 1, 1, 0); settle(); advance();
        set_id(1, 1, 1, 1, 1, 2, 1, 0); settle();
        chk("t1 stall_id", 16'(stall_id), 16'h0);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exm_dst_addr = 1; exm_we = 1; exm_result = 16'h00A5;
        settle();
        chk("t1 ex_op0", ex_op0, 16'h00A5);
        chk("t1 ex_op1", ex_op1, 16'h00A5);
        advance();

        // MEM/WB bypass, then EX/MEM priority
        clr_byp(); set_id(1, 3, 0, 1, 0, 9, 1, 0); settle(); advance();
        set_id(1, 3, 0, 1, 0, 10, 1, 0);
        exm_dst_addr = 4; exm_we = 1; exm_result = 16'h7777;
        mwb_dst_addr = 3; mwb_we = 1; mwb_result = 16'h1234;
        settle();
        chk("t2 mwb ex_op0", ex_op0, 16'h1234);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exm_dst_addr = 3; exm_result = 16'h5555;
        settle();
        chk("t2 exm ex_op0", ex_op0, 16'h5555);
        advance();

        // load-use stall
        clr_byp(); set_id(1, 0, 0, 0, 0, 5, 1, 1); settle(); advance();
        set_id(1, 5, 0, 1, 0, 6, 1, 0); settle();
        chk("t3 stall_id", 16'(stall_id), 16'h1);
        advance();
        settle();
        chk("t3 bubble ex_valid", 16'(ex_valid), 16'h0);
        chk("t3 stall released", 16'(stall_id), 16'h0);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        mwb_dst_addr = 5; mwb_we = 1; mwb_result = 16'hBEEF;
        settle();
        chk("t3 ex_op0", ex_op0, 16'hBEEF);
        chk("t3 stall_cnt", stall_cnt, 16'h0001);
        advance();

        // R0 never forwarded
        clr_byp(); set_id(1, 0, 0, 1, 1, 7, 1, 0); settle(); advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exm_dst_addr = 0; exm_we = 1; exm_result = 16'hFFFF;
        settle();
        chk("t4 ex_op0", ex_op0, 16'h0000);
        advance();

        // flush during stall, then halt
        clr_byp(); set_id(1, 0, 0, 0, 0, 5, 1, 1); settle(); advance();
        set_id(1, 5, 5, 1, 1, 6, 1, 0); flush = 1; settle();
        chk("t5 stall_id", 16'(stall_id), 16'h1);
        advance();
        flush = 0; set_id(1, 0, 0, 0, 0, 5, 1, 1); settle();
        chk("t5 flush bubble", 16'(ex_valid), 16'h0);
        chk("t5 stall_cnt", stall_cnt, 16'h0001);
        advance();
        set_id(1, 5, 0, 1, 0, 6, 1, 0); hlt = 1; settle(); advance();
        hlt = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(1, 5, 5, 1, 1, 5, 1, 1); settle();
            chk("t5 halted ex_valid", 16'(ex_valid), 16'h0);
            chk("t5 halted stall_id", 16'(stall_id), 16'h0);
            advance();
        end

        // reset mid-stall
        rst = 1; settle(); advance(); rst = 0;
        set_id(1, 0, 0, 0, 0, 5, 1, 1); settle(); advance();
        set_id(1, 5, 0, 1, 0, 6, 1, 0); settle();
        chk("t6 pre-rst stall", 16'(stall_id), 16'h1);
        chk("t6 pre-rst valid", 16'(ex_valid), 16'h1);
        rst = 1; advance(); rst = 0;
        clr_byp(); set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("t6 ex_valid", 16'(ex_valid), 16'h0);
        chk("t6 stall_id", 16'(stall_id), 16'h0);
        chk("t6 stall_cnt", stall_cnt, 16'h0);
        chk("t6 ex_op0", ex_op0, 16'h0);
        chk("t6 ex_op1", ex_op1, 16'h0);
        chk("t6 ex_dst_addr", 16'(ex_dst_addr), 16'h0);
        chk("t6 ex_ctrl", 16'(ex_ctrl), 16'h0);
        advance();

        for (int i = 0; i < 3000; i++) begin
            rand_in(); settle(); advance();
        end

        // saturation: a self-dependent load stalls every other cycle
        rst = 1; clr_byp(); settle(); advance(); rst = 0;
        for (int i = 0; i < 2 * 65540; i++) begin
            set_id(1, 5, 0, 1, 0, 5, 1, 1); settle(); advance();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("sat stall_cnt", stall_cnt, 16'hFFFF);
        advance();

        @(negedge clk);
        chk("scoreboard drained", 16'(q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
